fft_peak_det: RTL and testbench
===============================

Name: fft_peak_det

Overview:
- Sits directly downstream of the 1024-point fft core and consumes its o_strb/o_data bin stream.
- Computes per-bin power re^2+im^2 and tags each result with its bin index.
- Tracks the maximum-power bin over each frame and reports it once at frame end.
- Feeds spectrum display/logging and carrier-detect logic.

Parameters:
- N_LOG2, 10, log2 of FFT length; frame = 2^N_LOG2 bins.
- DW, 16, width of each signed real/imag component.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- n_reset  in  1  asynchronous active-low reset.
- i_strb  in  1  one-cycle valid for i_data; back-to-back allowed.
- i_data  in  2*DW  bin value: [2*DW-1:DW] real, [DW-1:0] imag, signed two's complement.
- i_sync  in  1  synchronous frame restart; clears bin counter and running peak.
- o_strb  out  1  valid for o_pwr/o_bin.
- o_pwr  out  2*DW  unsigned power of current bin.
- o_bin  out  N_LOG2  bin index of o_pwr.
- o_peak_strb  out  1  one-cycle pulse at frame end.
- o_peak_bin  out  N_LOG2  index of max-power bin of finished frame.
- o_peak_pwr  out  2*DW  power of that bin.

Behaviour:
- Reset (n_reset low, asynchronous): all outputs 0, bin counter 0, running peak 0, pipeline valids 0.
- Pipeline: stage 1 registers re*re and im*im (signed, 2*DW bits each) plus strobe and bin. Stage 2 registers the unsigned sum.
- o_strb asserts exactly 2 cycles after i_strb. o_pwr/o_bin hold between strobes.
- Width rule: max sum is (-2^(DW-1))^2*2 = 2^(2*DW-1), which fits unsigned 2*DW bits. No saturation is needed.
- Bin counter: increments on each accepted i_strb and wraps from 2^N_LOG2-1 to 0. o_bin is the counter value at acceptance.
- Peak tracking, evaluated at stage 2:
  - First bin of a frame (bin 0) loads the running peak unconditionally.
  - Later bins replace the running peak only on strictly greater power, so ties keep the lowest index.
- Frame end: when stage 2 processes bin 2^N_LOG2-1, o_peak_bin/o_peak_pwr are registered together with o_peak_strb.
  - o_peak_strb is high for one cycle, coincident with o_strb for the last bin.
  - o_peak_* hold until the next frame end.
- i_sync: bin counter is 0 on the next cycle. Running peak is cleared, and the in-flight stage-1/stage-2 samples are discarded (valids cleared). No o_peak_strb is produced for the aborted frame.
- i_sync with i_strb in the same cycle: i_sync wins the counter clear, then the sample is accepted as bin 0 of the new frame.
- Asynchronous reset mid-frame: same clearing as i_sync, plus all outputs reset.
- No backpressure: block accepts every i_strb. i_data is ignored when i_strb is low and may be X.

Optional Feature:
- Macro: FFT_PEAK_SKIP_DC_EN.
- Defined:
  - Bin 0 never updates the running peak; bin 1 loads it unconditionally.
  - Peak search covers bins 1..2^N_LOG2-1.
  - o_pwr/o_strb for bin 0 are still produced.
- Undefined: all bins participate as described above.

Decomposition:
- Package fft_pkg holds:
  - constants FFT_N_LOG2=10, FFT_DW=16;
  - typedef fft_cplx_t (packed struct re/im, signed DW);
  - typedef fft_pwr_t (unsigned 2*DW);
  - typedef fft_bin_t (N_LOG2 bits).
- One sub-module, fft_pwr_calc: the 2-stage square/sum pipeline carrying strobe and bin alongside.
- Peak tracker and bin counter live in fft_peak_det.

Test Plan:
- Reset then a single i_strb with i_data=32'h0003_0004 at bin 0 -> o_strb 2 cycles later, o_pwr=25, o_bin=0.
- Full frame, all bins 0 except bin 37=32'h0100_0000 -> o_peak_strb coincident with bin 1023 o_strb, o_peak_bin=37, o_peak_pwr=65536.
- Extreme value i_data=32'h8000_8000 -> o_pwr=32'h8000_0000, no overflow. Tie: bins 5 and 9 both 32'h0010_0010 (max) -> o_peak_bin=5.
- Back-to-back i_strb for 1024 cycles, then a second frame at 6-cycle spacing -> o_bin sequence 0..1023 twice, exactly two o_peak_strb pulses.
- i_sync asserted at bin 500, then a full frame -> no peak pulse for the aborted frame; the next peak reflects only the post-sync frame. Repeat with n_reset low mid-frame -> all outputs 0 immediately.
- FFT_PEAK_SKIP_DC_EN defined, bin 0=32'h7FFF_0000, bin 3=32'h0001_0000 -> o_peak_bin=3, o_peak_pwr=1. Undefined -> o_peak_bin=0.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared widths and types for the FFT bin post-processing blocks.
package fft_pkg;
    localparam int FFT_N_LOG2 = 10;
    localparam int FFT_DW     = 16;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } fft_cplx_t;

    typedef logic [2*FFT_DW-1:0]   fft_pwr_t;
    typedef logic [FFT_N_LOG2-1:0] fft_bin_t;
endpackage

// File: rtl/fft_pwr_calc.sv
// fft_pwr_calc: two-stage re^2+im^2 pipeline carrying strobe and bin index alongside.
// Stage-2 next-state values are exported so the peak tracker can register in step with o_strb.
module fft_pwr_calc
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2,
    parameter int DW     = FFT_DW
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              flush_i,
    input  logic              strb_i,
    input  logic [2*DW-1:0]   data_i,
    input  logic [N_LOG2-1:0] bin_i,
    output logic              s2_strb_o,
    output logic [2*DW-1:0]   s2_pwr_o,
    output logic [N_LOG2-1:0] s2_bin_o,
    output logic              strb_o,
    output logic [2*DW-1:0]   pwr_o,
    output logic [N_LOG2-1:0] bin_o
);
    logic signed [DW-1:0]   re, im;
    logic signed [2*DW-1:0] re_sq_q, im_sq_q;
    logic                   v1_q, v2_q;
    logic [N_LOG2-1:0]      bin1_q, bin2_q;
    logic [2*DW-1:0]        pwr_q;

    assign re = data_i[2*DW-1:DW];
    assign im = data_i[DW-1:0];
    // Largest sum is 2^(2*DW-1), so the unsigned add cannot overflow.
    assign s2_strb_o = v1_q & ~flush_i;
    assign s2_pwr_o  = $unsigned(re_sq_q) + $unsigned(im_sq_q);
    assign s2_bin_o  = bin1_q;
    assign strb_o    = v2_q;
    assign pwr_o     = pwr_q;
    assign bin_o     = bin2_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            re_sq_q <= '0;
            im_sq_q <= '0;
            bin1_q  <= '0;
            bin2_q  <= '0;
            pwr_q   <= '0;
        end else begin
            v1_q <= strb_i;
            v2_q <= s2_strb_o;
            if (strb_i) begin
                re_sq_q <= (2*DW)'(re) * (2*DW)'(re);
                im_sq_q <= (2*DW)'(im) * (2*DW)'(im);
                bin1_q  <= bin_i;
            end
            if (s2_strb_o) begin
                pwr_q  <= s2_pwr_o;
                bin2_q <= s2_bin_o;
            end
        end
    end
endmodule

// File: rtl/fft_peak_det.sv
// fft_peak_det: per-bin power plus per-frame max-power bin report.
// Define FFT_PEAK_SKIP_DC_EN to exclude bin 0 from the peak search.
module fft_peak_det
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2,
    parameter int DW     = FFT_DW
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              i_strb,
    input  logic [2*DW-1:0]   i_data,
    input  logic              i_sync,
    output logic              o_strb,
    output logic [2*DW-1:0]   o_pwr,
    output logic [N_LOG2-1:0] o_bin,
    output logic              o_peak_strb,
    output logic [N_LOG2-1:0] o_peak_bin,
    output logic [2*DW-1:0]   o_peak_pwr
);
    localparam logic [N_LOG2-1:0] LAST = '1;
`ifdef FFT_PEAK_SKIP_DC_EN
    localparam logic [N_LOG2-1:0] FIRST = N_LOG2'(1);
`else
    localparam logic [N_LOG2-1:0] FIRST = '0;
`endif

    logic [N_LOG2-1:0] cnt_q, cnt_d, in_bin, s2_bin, run_bin_q, run_bin_d, peak_bin_q;
    logic [2*DW-1:0]   s2_pwr, run_pwr_q, run_pwr_d, peak_pwr_q;
    logic              s2_strb, load, peak_strb_d, peak_strb_q;

    // A sync clears the count first, so a coincident strobe lands on bin 0.
    assign in_bin = i_sync ? '0 : cnt_q;
    assign cnt_d  = i_strb ? in_bin + N_LOG2'(1) : in_bin;

    fft_pwr_calc #(.N_LOG2(N_LOG2), .DW(DW)) u_pwr (
        .clk      (clk),
        .n_reset  (n_reset),
        .flush_i  (i_sync),
        .strb_i   (i_strb),
        .data_i   (i_data),
        .bin_i    (in_bin),
        .s2_strb_o(s2_strb),
        .s2_pwr_o (s2_pwr),
        .s2_bin_o (s2_bin),
        .strb_o   (o_strb),
        .pwr_o    (o_pwr),
        .bin_o    (o_bin)
    );

    // Strictly-greater replacement keeps the lowest index on ties.
    assign load        = s2_strb && (s2_bin == FIRST || (s2_bin > FIRST && s2_pwr > run_pwr_q));
    assign run_pwr_d   = i_sync ? '0 : load ? s2_pwr : run_pwr_q;
    assign run_bin_d   = i_sync ? '0 : load ? s2_bin : run_bin_q;
    assign peak_strb_d = s2_strb && s2_bin == LAST;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q       <= '0;
            run_pwr_q   <= '0;
            run_bin_q   <= '0;
            peak_strb_q <= 1'b0;
            peak_bin_q  <= '0;
            peak_pwr_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            run_pwr_q   <= run_pwr_d;
            run_bin_q   <= run_bin_d;
            peak_strb_q <= peak_strb_d;
            if (peak_strb_d) begin
                peak_bin_q <= run_bin_d;
                peak_pwr_q <= run_pwr_d;
            end
        end
    end

    assign o_peak_strb = peak_strb_q;
    assign o_peak_bin  = peak_bin_q;
    assign o_peak_pwr  = peak_pwr_q;
endmodule

// File: tb/tb_fft_peak_det.sv
// tb_fft_peak_det: directed and randomized frames checked against a queue/array reference model.
// Honours FFT_PEAK_SKIP_DC_EN the same way as the design.
module tb_fft_peak_det;
    import fft_pkg::*;

    typedef struct {
        fft_pwr_t pwr;
        fft_bin_t bin;
    } ent_t;

`ifdef FFT_PEAK_SKIP_DC_EN
    localparam int FIRST = 1;
    localparam logic [9:0]  DC_BIN = 10'd3;
    localparam logic [31:0] DC_PWR = 32'd1;
`else
    localparam int FIRST = 0;
    localparam logic [9:0]  DC_BIN = 10'd0;
    localparam logic [31:0] DC_PWR = 32'h3FFF_0001;
`endif

    logic        clk = 1'b0;
    logic        n_reset, i_strb, i_sync;
    logic [31:0] i_data;
    logic        o_strb, o_peak_strb;
    logic [31:0] o_pwr, o_peak_pwr;
    logic [9:0]  o_bin, o_peak_bin;

    ent_t        exp_q[$];
    ent_t        peak_q[$];
    ent_t        mon_e;
    fft_pwr_t    fr[1024];
    logic [31:0] fr_in[1024];
    int          tests = 0, fails = 0, pulses = 0, m_cnt = 0, p0;

    fft_peak_det dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .i_strb     (i_strb),
        .i_data     (i_data),
        .i_sync     (i_sync),
        .o_strb     (o_strb),
        .o_pwr      (o_pwr),
        .o_bin      (o_bin),
        .o_peak_strb(o_peak_strb),
        .o_peak_bin (o_peak_bin),
        .o_peak_pwr (o_peak_pwr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic fft_pwr_t pwr_of(input logic [31:0] d);
        fft_cplx_t c;
        longint    re, im;
        c  = d;
        re = longint'(c.re);
        im = longint'(c.im);
        return fft_pwr_t'(re * re + im * im);
    endfunction

    task automatic frame_end();
        int best = FIRST;
        for (int b = FIRST + 1; b < 1024; b++)
            if (fr[b] > fr[best]) best = b;
        peak_q.push_back('{fr[best], fft_bin_t'(best)});
    endtask

    // Called at posedge+1; drives one cycle and updates the model after the edge.
    task automatic send(input bit strb, input bit sync, input logic [31:0] d);
        i_strb = strb;
        i_sync = sync;
        i_data = strb ? d : 'x;
        @(posedge clk);
        #1;
        if (sync) begin
            exp_q.delete();
            m_cnt = 0;
        end
        if (strb) begin
            fr[m_cnt] = pwr_of(d);
            exp_q.push_back('{fr[m_cnt], fft_bin_t'(m_cnt)});
            if (m_cnt == 1023) frame_end();
            m_cnt = (m_cnt + 1) % 1024;
        end
        i_strb = 1'b0;
        i_sync = 1'b0;
        i_data = 'x;
    endtask

    task automatic run_frame(input int gap, input bit sync_first);
        for (int b = 0; b < 1024; b++) begin
            send(1'b1, sync_first && b == 0, fr_in[b]);
            repeat (gap - 1) send(1'b0, 1'b0, '0);
        end
        repeat (4) send(1'b0, 1'b0, '0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_strb"}, o_strb, 1'b0);
        chk({tag, "_pwr"}, o_pwr, 32'd0);
        chk({tag, "_bin"}, o_bin, 10'd0);
        chk({tag, "_pk_strb"}, o_peak_strb, 1'b0);
        chk({tag, "_pk_bin"}, o_peak_bin, 10'd0);
        chk({tag, "_pk_pwr"}, o_peak_pwr, 32'd0);
    endtask

    always @(negedge clk) begin
        if (n_reset === 1'b1) begin
            if (o_strb) begin
                if (exp_q.size() == 0) chk("spurious_strb", o_strb, 1'b0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("pwr", o_pwr, mon_e.pwr);
                    chk("bin", o_bin, mon_e.bin);
                end
            end
            if (o_peak_strb) begin
                pulses++;
                chk("peak_coinc", {o_strb, o_bin}, {1'b1, 10'h3FF});
                if (peak_q.size() == 0) chk("spurious_peak", o_peak_strb, 1'b0);
                else begin
                    mon_e = peak_q.pop_front();
                    chk("peak_bin", o_peak_bin, mon_e.bin);
                    chk("peak_pwr", o_peak_pwr, mon_e.pwr);
                end
            end
        end
    end

    initial begin
        n_reset = 1'b0;
        i_strb  = 1'b0;
        i_sync  = 1'b0;
        i_data  = 'x;
        #12;
        chk_zero("reset");
        n_reset = 1'b1;
        @(posedge clk);
        #1;

        send(1'b1, 1'b0, 32'h0003_0004);
        @(negedge clk);
        chk("lat1_strb", o_strb, 1'b0);
        @(negedge clk);
        chk("lat2_strb", o_strb, 1'b1);
        chk("lat2_pwr", o_pwr, 32'd25);
        chk("lat2_bin", o_bin, 10'd0);
        @(posedge clk);
        #1;
        send(1'b0, 1'b1, '0);

        foreach (fr_in[b]) fr_in[b] = '0;
        fr_in[37] = 32'h0100_0000;
        run_frame(1, 1'b0);
        chk("f37_bin", o_peak_bin, 10'd37);
        chk("f37_pwr", o_peak_pwr, 32'd65536);

        foreach (fr_in[b]) fr_in[b] = '0;
        fr_in[5] = 32'h0010_0010;
        fr_in[9] = 32'h0010_0010;
        run_frame(1, 1'b0);
        chk("tie_bin", o_peak_bin, 10'd5);
        chk("tie_pwr", o_peak_pwr, 32'd512);

        p0 = pulses;
        foreach (fr_in[b]) fr_in[b] = $urandom();
        fr_in[100] = 32'h8000_8000;
        run_frame(1, 1'b0);
        chk("max_pwr", o_peak_pwr, 32'h8000_0000);
        foreach (fr_in[b]) fr_in[b] = $urandom();
        run_frame(6, 1'b0);
        chk("two_pulses", pulses - p0, 2);

        p0 = pulses;
        foreach (fr_in[b]) fr_in[b] = $urandom() & 32'h00FF_00FF;
        fr_in[10] = 32'h7FFF_7FFF;
        for (int b = 0; b < 500; b++) send(1'b1, 1'b0, fr_in[b]);
        send(1'b0, 1'b1, '0);
        fr_in[10] = $urandom() & 32'h00FF_00FF;
        run_frame(1, 1'b0);
        for (int b = 0; b < 300; b++) send(1'b1, 1'b0, 32'h7FFF_7FFF);
        foreach (fr_in[b]) fr_in[b] = $urandom() & 32'h00FF_00FF;
        run_frame(2, 1'b1);
        chk("sync_pulses", pulses - p0, 2);

        for (int b = 0; b < 200; b++) send(1'b1, 1'b0, $urandom());
        n_reset = 1'b0;
        #1;
        chk_zero("midrst");
        exp_q.delete();
        peak_q.delete();
        m_cnt = 0;
        #3;
        n_reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (fr_in[b]) fr_in[b] = '0;
        fr_in[0] = 32'h7FFF_0000;
        fr_in[3] = 32'h0001_0000;
        run_frame(1, 1'b0);
        chk("dc_bin", o_peak_bin, DC_BIN);
        chk("dc_pwr", o_peak_pwr, DC_PWR);

        chk("exp_q_drained", exp_q.size(), 0);
        chk("peak_q_drained", peak_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
